truth_table_scanner: RTL and testbench
======================================

Name: truth_table_scanner

Overview:
Sequential exerciser, the inverse of a 3-input, 2-output combinational function block. It drives x, y, z through all 8 input vectors in order, waits a settle interval per vector, and samples the F1/F2 responses. From those samples it rebuilds both truth tables as 8-bit minterm masks and compares them against expected masks. It sits on the lab board between control (button/start) and the unit under evaluation.

Parameters:
SETTLE_CYCLES, 2, extra cycles each vector is held before sampling; legal range 0..15
EXP_F1, 8'h93, expected F1 minterm mask; bit i = F1 at {x,y,z}=i
EXP_F2, 8'h93, expected F2 minterm mask; same bit mapping

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous, active-low reset
start  input  1  begin a scan; accepted only in IDLE
abort  input  1  synchronous abort; returns to IDLE
f1_in  input  1  F1 response from the unit under evaluation
f2_in  input  1  F2 response from the unit under evaluation
x  output  1  stimulus MSB (idx[2])
y  output  1  stimulus (idx[1])
z  output  1  stimulus LSB (idx[0])
busy  output  1  high while scanning
done  output  1  one-cycle pulse after the last sample
f1_mask  output  8  captured F1 truth table
f2_mask  output  8  captured F2 truth table
f1_ok  output  1  f1_mask == EXP_F1; valid from done until next start
f2_ok  output  1  f2_mask == EXP_F2; valid from done until next start

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, idx=0, settle counter=0, x/y/z=0, busy=0, done=0, masks=8'h00, f1_ok=f2_ok=0.
- All outputs are registered. {x,y,z} = idx at all times.
- States: IDLE, SCAN, DONE.
- IDLE: start=1 at edge -> SCAN, idx=0, counter=0, masks cleared to 0, f1_ok/f2_ok cleared, busy=1 from the next cycle.
- SCAN: each vector is held for SETTLE_CYCLES+1 cycles.
  - Counter increments each cycle.
  - On the edge where counter==SETTLE_CYCLES: f1_mask[idx] <= f1_in, f2_mask[idx] <= f2_in, counter <= 0.
  - If idx==7 on that edge -> DONE; otherwise idx <= idx+1.
- DONE: lasts exactly 1 cycle with done=1, busy=0. f1_ok/f2_ok are updated on entry. Next state is IDLE; start in the DONE cycle is ignored.
- Scan length: start edge at cycle 0 -> busy for cycles 1..8*(SETTLE_CYCLES+1) -> done in the following cycle. Default: busy cycles 1..24, done at cycle 25.
- Wrap: idx never advances past 7. x/y/z hold 3'b111 through DONE and return to 000 in IDLE.
- start while busy or in DONE: ignored, no restart.
- abort in SCAN: next state IDLE, busy=0, idx=0, masks=0, no done pulse. abort has priority over a same-edge sample. abort in IDLE/DONE: no effect, except DONE still proceeds to IDLE.
- start and abort together in IDLE: abort wins; remain in IDLE.
- Reset mid-scan: immediate return to reset values; no done pulse.
- Masks and ok flags hold their values from DONE until the next accepted start.
- f1_in/f2_in are synchronous to clk, being combinational from x/y/z. The settle interval covers propagation; no synchronizer.

Decomposition:
- Shared package/header: state encoding (IDLE=2'd0, SCAN=2'd1, DONE=2'd2), NUM_VECTORS=8, default EXP mask constant 8'h93.
- One sub-module is natural: settle_timer (counter plus terminal-count flag, width 4). FSM, index and mask capture stay in the top.

Test Plan:
- Correct model (F1=F2=mask 8'h93) attached, start at cycle 0 -> busy cycles 1..24; x/y/z step 000..111, each held 3 cycles; done at cycle 25; f1_mask=f2_mask=8'h93; f1_ok=f2_ok=1.
- F2 model stuck-at-0 -> f2_mask=8'h00, f2_ok=0; f1_mask=8'h93, f1_ok=1.
- SETTLE_CYCLES=0, F1 model = x^y^z -> done at cycle 9; f1_mask=8'h96, f1_ok=0.
- start re-pulsed at cycle 10 during a scan -> no restart; done still at cycle 25.
- abort at cycle 11 (idx=3) -> IDLE next cycle; busy=0, masks=8'h00, no done pulse. A following start gives a full, correct scan.
- rst_n low at cycle 7 (asynchronous, mid-cycle) -> outputs at reset values immediately; after release and start, the scan completes normally with masks 8'h93.

Source files
------------

// File: rtl/truth_table_scanner_pkg.sv
// Shared definitions for the truth table scanner.
// - state_t          : scanner FSM state encoding
// - NUM_VECTORS      : number of input vectors for a 3-input function
// - DEFAULT_EXP_MASK : default expected minterm mask for F1 and F2
// - TIMER_W          : width of the settle counter
package truth_table_scanner_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int NUM_VECTORS = 8;
  localparam logic [7:0] DEFAULT_EXP_MASK = 8'h93;
  localparam int TIMER_W = 4;
  localparam logic [2:0] LAST_IDX = 3'(NUM_VECTORS - 1);

endpackage

// File: rtl/truth_table_scanner_settle_timer.sv
// Settle interval counter for the truth table scanner.
// Counts 0..SETTLE_CYCLES while enabled, wrapping to 0 after the terminal
// count. tc is high during the cycle in which the count equals SETTLE_CYCLES,
// i.e. the cycle whose closing edge samples the responses.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : synchronous return to 0 (has priority over enable)
//   enable     : advance the count
//   tc         : terminal-count flag
module truth_table_scanner_settle_timer
  import truth_table_scanner_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam logic [TIMER_W-1:0] TC_VAL = TIMER_W'(SETTLE_CYCLES);

  logic [TIMER_W-1:0] count;

  assign tc = (count == TC_VAL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= tc ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/truth_table_scanner.sv
// Truth table scanner: drives {x,y,z} through vectors 0..7, holds each one
// SETTLE_CYCLES+1 cycles, samples f1_in/f2_in on the last cycle of each
// vector and assembles the F1/F2 minterm masks (bit i = response at {x,y,z}=i).
// At the end the masks are compared with EXP_F1/EXP_F2.
//
// Handshake: start is a request that is accepted only on an edge where the
// FSM is in IDLE and abort is low; it is ignored at any other time. Completion
// is signalled by a one-cycle done pulse; masks and ok flags stay valid from
// done until the next accepted start. abort in SCAN drops the scan silently.
//
// Ports:
//   clk, rst_n       : clock, asynchronous active-low reset
//   start, abort     : scan request / synchronous cancel
//   f1_in, f2_in     : responses of the unit under evaluation
//   x, y, z          : stimulus, {x,y,z} = current vector index
//   busy, done       : scan in progress / one-cycle completion pulse
//   f1_mask, f2_mask : captured truth tables
//   f1_ok, f2_ok     : captured mask equals expected mask
//   dbg_state        : current FSM state
module truth_table_scanner
  import truth_table_scanner_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter logic [7:0]  EXP_F1        = DEFAULT_EXP_MASK,
  parameter logic [7:0]  EXP_F2        = DEFAULT_EXP_MASK
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic       f1_in,
  input  logic       f2_in,
  output logic       x,
  output logic       y,
  output logic       z,
  output logic       busy,
  output logic       done,
  output logic [7:0] f1_mask,
  output logic [7:0] f2_mask,
  output logic       f1_ok,
  output logic       f2_ok,
  output state_t     dbg_state
);

  state_t     state;
  logic [2:0] idx;
  logic       sample;
  logic [7:0] f1_next;
  logic [7:0] f2_next;

  // Stimulus comes straight from the index register, so it is registered.
  assign {x, y, z} = idx;
  assign dbg_state = state;

  truth_table_scanner_settle_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_settle_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clear ((state != ST_SCAN) || abort),
    .enable(state == ST_SCAN),
    .tc    (sample)
  );

  // Masks including the bit captured on this edge; the ok flags compare the
  // complete masks on the same edge that stores the last bit.
  always_comb begin
    f1_next      = f1_mask;
    f2_next      = f2_mask;
    f1_next[idx] = f1_in;
    f2_next[idx] = f2_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      idx     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      f1_mask <= '0;
      f2_mask <= '0;
      f1_ok   <= 1'b0;
      f2_ok   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start && !abort) begin
            state   <= ST_SCAN;
            idx     <= '0;
            busy    <= 1'b1;
            f1_mask <= '0;
            f2_mask <= '0;
            f1_ok   <= 1'b0;
            f2_ok   <= 1'b0;
          end
        end
        ST_SCAN: begin
          if (abort) begin
            // abort outranks a sample on the same edge
            state   <= ST_IDLE;
            idx     <= '0;
            busy    <= 1'b0;
            f1_mask <= '0;
            f2_mask <= '0;
          end else if (sample) begin
            f1_mask <= f1_next;
            f2_mask <= f2_next;
            if (idx == LAST_IDX) begin
              // idx stays at 7 so x/y/z hold 111 through DONE
              state <= ST_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              f1_ok <= (f1_next == EXP_F1);
              f2_ok <= (f2_next == EXP_F2);
            end else begin
              idx <= idx + 3'd1;
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          done  <= 1'b0;
          idx   <= '0;
        end
        default: begin
          state <= ST_IDLE;
          idx   <= '0;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_scanner.sv
module tb_truth_table_scanner;
  import truth_table_scanner_pkg::*;

  localparam int S_A   = 2;
  localparam int LEN_A = 8 * (S_A + 1);
  localparam int S_B   = 0;
  localparam int LEN_B = 8 * (S_B + 1);
  localparam logic [7:0] EXP = 8'h93;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  // ---------------- DUT A: default settle, table-driven unit ----------------
  logic       start_a = 1'b0, abort_a = 1'b0;
  logic       f1_a, f2_a, x_a, y_a, z_a, busy_a, done_a, ok1_a, ok2_a;
  logic [7:0] f1m_a, f2m_a;
  logic [7:0] tbl_f1_a = 8'h00, tbl_f2_a = 8'h00;
  state_t     st_a;

  assign f1_a = tbl_f1_a[{x_a, y_a, z_a}];
  assign f2_a = tbl_f2_a[{x_a, y_a, z_a}];

  truth_table_scanner #(.SETTLE_CYCLES(S_A), .EXP_F1(EXP), .EXP_F2(EXP)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a),
    .f1_in(f1_a), .f2_in(f2_a), .x(x_a), .y(y_a), .z(z_a),
    .busy(busy_a), .done(done_a), .f1_mask(f1m_a), .f2_mask(f2m_a),
    .f1_ok(ok1_a), .f2_ok(ok2_a), .dbg_state(st_a)
  );

  // ---------------- DUT B: zero settle, F1 = x^y^z ----------------
  logic       start_b = 1'b0, abort_b = 1'b0;
  logic       f1_b, f2_b, x_b, y_b, z_b, busy_b, done_b, ok1_b, ok2_b;
  logic [7:0] f1m_b, f2m_b;
  logic [7:0] tbl_f2_b = EXP;
  state_t     st_b;

  assign f1_b = x_b ^ y_b ^ z_b;
  assign f2_b = tbl_f2_b[{x_b, y_b, z_b}];

  truth_table_scanner #(.SETTLE_CYCLES(S_B), .EXP_F1(EXP), .EXP_F2(EXP)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b),
    .f1_in(f1_b), .f2_in(f2_b), .x(x_b), .y(y_b), .z(z_b),
    .busy(busy_b), .done(done_b), .f1_mask(f1m_b), .f2_mask(f2m_b),
    .f1_ok(ok1_b), .f2_ok(ok2_b), .dbg_state(st_b)
  );

  // ---------------- scoreboard ----------------
  // entry = {done cycle[31:0], f2_ok, f1_ok, f2_mask, f1_mask}
  logic [49:0] exp_q[$];
  logic [49:0] exp_q_b[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [49:0] pack_exp(input int d, input logic [7:0] f1, input logic [7:0] f2);
    return {32'(d), (f2 == EXP), (f1 == EXP), f2, f1};
  endfunction

  // bits of vectors already sampled, after v vectors
  function automatic logic [7:0] low_mask(input int v);
    logic [8:0] m;
    m = (9'd1 << v) - 9'd1;
    return m[7:0];
  endfunction

  // ---------------- monitor A ----------------
  always @(negedge clk) begin
    logic [49:0] e;
    int d, c0, v;
    if (rst_n) begin
      if (exp_q.size() > 0) begin
        e  = exp_q[0];
        d  = int'(e[49:18]);
        c0 = d - LEN_A;
        if (cyc >= c0 && cyc < d) begin
          v = (cyc - c0) / (S_A + 1);
          check("scan_busy", busy_a, 1);
          check("scan_done_low", done_a, 0);
          check("scan_xyz", {x_a, y_a, z_a}, v);
          check("scan_f1_partial", f1m_a, e[7:0] & low_mask(v));
          check("scan_f2_partial", f2m_a, e[15:8] & low_mask(v));
          check("scan_ok_low", {ok2_a, ok1_a}, 0);
        end
      end
      if (done_a) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done actual=1 expected=0 (cycle %0d)", cyc);
        end else begin
          e = exp_q.pop_front();
          check("done_cycle", cyc, e[49:18]);
          check("done_f1_mask", f1m_a, e[7:0]);
          check("done_f2_mask", f2m_a, e[15:8]);
          check("done_f1_ok", ok1_a, e[16]);
          check("done_f2_ok", ok2_a, e[17]);
          check("done_busy_low", busy_a, 0);
          check("done_xyz", {x_a, y_a, z_a}, 7);
        end
      end
    end
  end

  // ---------------- monitor B ----------------
  always @(negedge clk) begin
    logic [49:0] e;
    if (rst_n && done_b) begin
      if (exp_q_b.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done_b actual=1 expected=0 (cycle %0d)", cyc);
      end else begin
        e = exp_q_b.pop_front();
        check("b_done_cycle", cyc, e[49:18]);
        check("b_f1_mask", f1m_b, e[7:0]);
        check("b_f2_mask", f2m_b, e[15:8]);
        check("b_f1_ok", ok1_b, e[16]);
        check("b_f2_ok", ok2_b, e[17]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic run_scan_a(input logic [7:0] t1, input logic [7:0] t2,
                            input bit repulse, input bit start_in_done);
    int c;
    bit seen;
    @(negedge clk);
    tbl_f1_a = t1;
    tbl_f2_a = t2;
    start_a  = 1'b1;
    exp_q.push_back(pack_exp(cyc + 1 + LEN_A, t1, t2));
    @(negedge clk);
    start_a = 1'b0;
    c = cyc;
    seen = 1'b0;
    for (int i = 0; i < LEN_A + 8; i++) begin
      if (done_a) begin
        seen = 1'b1;
        break;
      end
      start_a = repulse && (cyc == c + 9);
      @(negedge clk);
    end
    start_a = 1'b0;
    check("scan_timeout", seen, 1);
    if (!seen) exp_q.delete();
    if (start_in_done) start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    check("idle_busy", busy_a, 0);
    check("idle_done", done_a, 0);
    check("idle_xyz", {x_a, y_a, z_a}, 0);
    check("idle_state", st_a, ST_IDLE);
    check("hold_f1_mask", f1m_a, t1);
    check("hold_f2_mask", f2m_a, t2);
    check("hold_ok", {ok2_a, ok1_a}, {31'(t2 == EXP), t1 == EXP});
  endtask

  task automatic abort_test;
    int c;
    @(negedge clk);
    tbl_f1_a = EXP;
    tbl_f2_a = EXP;
    start_a  = 1'b1;
    exp_q.push_back(pack_exp(cyc + 1 + LEN_A, EXP, EXP));
    @(negedge clk);
    start_a = 1'b0;
    c = cyc;
    while (cyc < c + 10) @(negedge clk);
    abort_a = 1'b1;
    exp_q.delete();
    @(negedge clk);
    abort_a = 1'b0;
    check("abort_busy", busy_a, 0);
    check("abort_masks", {f2m_a, f1m_a}, 0);
    check("abort_xyz", {x_a, y_a, z_a}, 0);
    check("abort_state", st_a, ST_IDLE);
    repeat (LEN_A + 4) @(negedge clk);
  endtask

  task automatic reset_test;
    int c;
    @(negedge clk);
    tbl_f1_a = EXP;
    tbl_f2_a = EXP;
    start_a  = 1'b1;
    exp_q.push_back(pack_exp(cyc + 1 + LEN_A, EXP, EXP));
    @(negedge clk);
    start_a = 1'b0;
    c = cyc;
    while (cyc < c + 6) @(negedge clk);
    #1;
    exp_q.delete();
    rst_n = 1'b0;
    #1;
    check("rst_busy", busy_a, 0);
    check("rst_done", done_a, 0);
    check("rst_xyz", {x_a, y_a, z_a}, 0);
    check("rst_masks", {f2m_a, f1m_a}, 0);
    check("rst_state", st_a, ST_IDLE);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (LEN_A) @(negedge clk);
  endtask

  task automatic run_scan_b;
    logic [7:0] f1_exp;
    bit seen;
    for (int i = 0; i < 8; i++) f1_exp[i] = ^(3'(i));
    @(negedge clk);
    start_b = 1'b1;
    exp_q_b.push_back(pack_exp(cyc + 1 + LEN_B, f1_exp, tbl_f2_b));
    @(negedge clk);
    start_b = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < LEN_B + 8; i++) begin
      if (done_b) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("b_scan_timeout", seen, 1);
    if (!seen) exp_q_b.delete();
    @(negedge clk);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [7:0] t1, t2;
    @(negedge clk);
    check("reset_busy", busy_a, 0);
    check("reset_done", done_a, 0);
    check("reset_xyz", {x_a, y_a, z_a}, 0);
    check("reset_masks", {f2m_a, f1m_a}, 0);
    check("reset_ok", {ok2_a, ok1_a}, 0);
    check("reset_state", st_a, ST_IDLE);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_scan_a(EXP, EXP, 1'b0, 1'b0);     // correct unit
    run_scan_a(EXP, 8'h00, 1'b0, 1'b0);   // F2 stuck-at-0
    run_scan_a(EXP, EXP, 1'b1, 1'b0);     // start re-pulsed mid-scan
    run_scan_a(8'h5A, EXP, 1'b0, 1'b1);   // start during DONE ignored
    abort_test();
    run_scan_a(EXP, EXP, 1'b0, 1'b0);     // full scan after abort

    // start and abort together in IDLE: abort wins
    @(negedge clk);
    start_a = 1'b1;
    abort_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    abort_a = 1'b0;
    check("start_abort_busy", busy_a, 0);
    check("start_abort_state", st_a, ST_IDLE);
    repeat (3) @(negedge clk);

    run_scan_b();

    for (int n = 0; n < 10; n++) begin
      t1 = ($urandom_range(0, 3) == 0) ? EXP : 8'($urandom);
      t2 = ($urandom_range(0, 3) == 0) ? EXP : 8'($urandom);
      run_scan_a(t1, t2, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    reset_test();
    run_scan_a(EXP, EXP, 1'b0, 1'b0);     // normal scan after reset

    repeat (5) @(negedge clk);
    check("queue_a_empty", exp_q.size(), 0);
    check("queue_b_empty", exp_q_b.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
